// File: rtl/distinct_ctrl_pkg.sv
// Shared aggregation types: key width and the packed beats exchanged with the
// distinct hash table and the downstream consumer.
package aggTypes;

  localparam int AGG_KEY_BITS = 16;

  typedef logic [AGG_KEY_BITS-1:0] agg_key_t;

  typedef struct packed {
    agg_key_t key;
    logic     last;
  } key_beat_t;

  typedef struct packed {
    agg_key_t key;
    logic     hit;
    logic     last;
  } lup_rsp_t;

  typedef struct packed {
    agg_key_t key;
    logic     last;
    logic     keep;
  } out_beat_t;

endpackage

// File: rtl/distinct_ctrl_infl_fifo.sv
// Register-based FIFO holding keys whose lookup is outstanding; the head is
// visible combinationally so the response can be matched in the same cycle.
module infl_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only; a pop never frees a slot
  // for a push in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/distinct_ctrl.sv
// Filters a key stream down to first occurrences per batch, using table
// lookups plus a small window of recent inserts not yet visible in the table.
module distinct_ctrl
  import aggTypes::*;
#(
  parameter int INFL_DEPTH = 8,
  parameter int WIN_DEPTH  = 4
) (
  input  logic      aclk,
  input  logic      aresetn,
  input  logic      s_key_valid,
  output logic      s_key_ready,
  input  key_beat_t s_key_data,
  output logic      m_lup_req_valid,
  input  logic      m_lup_req_ready,
  output key_beat_t m_lup_req_data,
  input  logic      s_lup_rsp_valid,
  output logic      s_lup_rsp_ready,
  input  lup_rsp_t  s_lup_rsp_data,
  output logic      m_upd_req_valid,
  input  logic      m_upd_req_ready,
  output agg_key_t  m_upd_req_data,
  output logic      m_out_valid,
  input  logic      m_out_ready,
  output out_beat_t m_out_data,
  output logic      err_orphan
);

  localparam int WAW = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;

  logic                  infl_full;
  logic                  infl_empty;
  logic [AGG_KEY_BITS:0] head_bits;
  key_beat_t             head;
  logic                  lup_fire;
  logic                  rsp_fire;
  logic                  win_match;
  logic                  dup;
  agg_key_t              win_key [WIN_DEPTH];
  logic [WIN_DEPTH-1:0]  win_vld;
  logic [WIN_DEPTH-1:0]  hit_vec;
  logic [WAW-1:0]        win_ptr;
  logic [WAW-1:0]        win_ptr_next;
  logic                  unused_rsp_bits;

  assign m_lup_req_valid = s_key_valid & ~infl_full & aresetn;
  assign s_key_ready     = m_lup_req_ready & ~infl_full & aresetn;
  assign m_lup_req_data  = s_key_data;
  assign lup_fire        = m_lup_req_valid & m_lup_req_ready;

  assign s_lup_rsp_ready = (~m_out_valid | m_out_ready) &
                           (~m_upd_req_valid | m_upd_req_ready) & ~infl_empty;
  assign rsp_fire        = s_lup_rsp_valid & s_lup_rsp_ready;

  // The response key/last are ignored; the FIFO head is authoritative.
  assign unused_rsp_bits = ^{s_lup_rsp_data.key, s_lup_rsp_data.last};

  infl_fifo #(
    .WIDTH (AGG_KEY_BITS + 1),
    .DEPTH (INFL_DEPTH)
  ) u_infl_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (lup_fire),
    .push_data (m_lup_req_data),
    .pop       (rsp_fire),
    .head      (head_bits),
    .full      (infl_full),
    .empty     (infl_empty)
  );

  assign head = key_beat_t'(head_bits);

  for (genvar gi = 0; gi < WIN_DEPTH; gi++) begin : g_win_cmp
    assign hit_vec[gi] = win_vld[gi] & (win_key[gi] == head.key);
  end

  assign win_match    = |hit_vec;
  assign dup          = s_lup_rsp_data.hit | win_match;
  assign win_ptr_next = (win_ptr == WAW'(WIN_DEPTH - 1)) ? '0 : win_ptr + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_out_valid     <= 1'b0;
      m_out_data      <= '0;
      m_upd_req_valid <= 1'b0;
      m_upd_req_data  <= '0;
      err_orphan      <= 1'b0;
      win_vld         <= '0;
      win_ptr         <= '0;
      for (int i = 0; i < WIN_DEPTH; i++) win_key[i] <= '0;
    end else begin
      if (m_out_valid & m_out_ready)         m_out_valid     <= 1'b0;
      if (m_upd_req_valid & m_upd_req_ready) m_upd_req_valid <= 1'b0;
      if (s_lup_rsp_valid & infl_empty)      err_orphan      <= 1'b1;
      if (rsp_fire) begin
        if (!dup) begin
          m_out_valid      <= 1'b1;
          m_out_data       <= {head.key, head.last, 1'b1};
          m_upd_req_valid  <= 1'b1;
          m_upd_req_data   <= head.key;
          win_key[win_ptr] <= head.key;
          win_vld[win_ptr] <= 1'b1;
          win_ptr          <= win_ptr_next;
        end else if (head.last) begin
          m_out_valid <= 1'b1;
          m_out_data  <= {head.key, 1'b1, 1'b0};
        end
        // End of batch: the table is cleared, so the window must be too.
        if (head.last) win_vld <= '0;
      end
    end
  end

endmodule

// File: tb/tb_distinct_ctrl.sv
// Directed scoreboard bench for distinct_ctrl: stimulus pushes expected beats,
// a monitor pops and compares on every m_out / m_upd_req handshake.
module tb_distinct_ctrl;
  import aggTypes::*;

  localparam int INFL_DEPTH = 8;
  localparam int WIN_DEPTH  = 4;

  logic      aclk = 1'b0;
  logic      aresetn;
  logic      s_key_valid;
  logic      s_key_ready;
  key_beat_t s_key_data;
  logic      m_lup_req_valid;
  logic      m_lup_req_ready;
  key_beat_t m_lup_req_data;
  logic      s_lup_rsp_valid;
  logic      s_lup_rsp_ready;
  lup_rsp_t  s_lup_rsp_data;
  logic      m_upd_req_valid;
  logic      m_upd_req_ready;
  agg_key_t  m_upd_req_data;
  logic      m_out_valid;
  logic      m_out_ready;
  out_beat_t m_out_data;
  logic      err_orphan;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  out_beat_t exp_out [$];
  agg_key_t  exp_upd [$];

  always #5 aclk = ~aclk;

  distinct_ctrl #(
    .INFL_DEPTH (INFL_DEPTH),
    .WIN_DEPTH  (WIN_DEPTH)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_key_valid     (s_key_valid),
    .s_key_ready     (s_key_ready),
    .s_key_data      (s_key_data),
    .m_lup_req_valid (m_lup_req_valid),
    .m_lup_req_ready (m_lup_req_ready),
    .m_lup_req_data  (m_lup_req_data),
    .s_lup_rsp_valid (s_lup_rsp_valid),
    .s_lup_rsp_ready (s_lup_rsp_ready),
    .s_lup_rsp_data  (s_lup_rsp_data),
    .m_upd_req_valid (m_upd_req_valid),
    .m_upd_req_ready (m_upd_req_ready),
    .m_upd_req_data  (m_upd_req_data),
    .m_out_valid     (m_out_valid),
    .m_out_ready     (m_out_ready),
    .m_out_data      (m_out_data),
    .err_orphan      (err_orphan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic out_beat_t ob(input int k, input logic l, input logic kp);
    out_beat_t b;
    b.key  = agg_key_t'(k);
    b.last = l;
    b.keep = kp;
    return b;
  endfunction

  task automatic exp_o(input int k, input logic l, input logic kp);
    exp_out.push_back(ob(k, l, kp));
  endtask

  task automatic exp_u(input int k);
    exp_upd.push_back(agg_key_t'(k));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge aclk) begin
    out_beat_t eo;
    agg_key_t  eu;
    if (aresetn === 1'b1 && m_out_valid && m_out_ready) begin
      if (exp_out.size() == 0) begin
        vec_cnt++;
        miscmp_cnt++;
        $display("FAIL out_unexpected: got %h expected none", m_out_data);
      end else begin
        eo = exp_out.pop_front();
        $display("out beat key=%0d last=%0d keep=%0d", m_out_data.key, m_out_data.last, m_out_data.keep);
        chk("out_beat", 32'(m_out_data), 32'(eo));
      end
    end
    if (aresetn === 1'b1 && m_upd_req_valid && m_upd_req_ready) begin
      if (exp_upd.size() == 0) begin
        vec_cnt++;
        miscmp_cnt++;
        $display("FAIL upd_unexpected: got %h expected none", m_upd_req_data);
      end else begin
        eu = exp_upd.pop_front();
        $display("upd req key=%0d", m_upd_req_data);
        chk("upd_key", 32'(m_upd_req_data), 32'(eu));
      end
    end
  end

  task automatic send_key(input int k, input logic l);
    s_key_valid     = 1'b1;
    s_key_data.key  = agg_key_t'(k);
    s_key_data.last = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_key_ready) begin
        tick();
        s_key_valid = 1'b0;
        return;
      end
    end
    chk("key_timeout", 32'd0, 32'd1);
    s_key_valid = 1'b0;
  endtask

  // Response key/last carry junk so any use of them instead of the head shows.
  task automatic send_rsp(input logic hit);
    s_lup_rsp_valid     = 1'b1;
    s_lup_rsp_data.key  = 16'hBEEF;
    s_lup_rsp_data.hit  = hit;
    s_lup_rsp_data.last = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_lup_rsp_ready) begin
        tick();
        s_lup_rsp_valid = 1'b0;
        return;
      end
    end
    chk("rsp_timeout", 32'd0, 32'd1);
    s_lup_rsp_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_out.size() == 0 && exp_upd.size() == 0) break;
      tick();
    end
    tick();
    chk("drain_out_q", 32'(exp_out.size()), 32'd0);
    chk("drain_upd_q", 32'(exp_upd.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn         = 1'b0;
    s_key_valid     = 1'b1;
    s_key_data      = '0;
    m_lup_req_ready = 1'b1;
    s_lup_rsp_valid = 1'b0;
    s_lup_rsp_data  = '0;
    m_upd_req_ready = 1'b1;
    m_out_ready     = 1'b1;

    // Reset state, with a key offered to prove lookups are blocked.
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_lup_valid", 32'(m_lup_req_valid), 32'd0);
    chk("rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("rst_upd_valid", 32'(m_upd_req_valid), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    tick();
    s_key_valid = 1'b0;
    aresetn     = 1'b1;
    tick();
    @(negedge aclk);
    chk("idle_key_ready", 32'(s_key_ready), 32'd1);
    chk("idle_rsp_ready", 32'(s_lup_rsp_ready), 32'd0);
    tick();

    // 5, 7, 5(last): repeat caught by the window, emitted as last/keep=0.
    exp_o(5, 1'b0, 1'b1); exp_u(5);
    exp_o(7, 1'b0, 1'b1); exp_u(7);
    exp_o(5, 1'b1, 1'b0);
    send_key(5, 1'b0); send_key(7, 1'b0); send_key(5, 1'b1);
    send_rsp(1'b0); send_rsp(1'b0); send_rsp(1'b0);
    drain();

    // 9, 9 with back-to-back misses; then a table hit closing the batch.
    exp_o(9, 1'b0, 1'b1); exp_u(9);
    send_key(9, 1'b0); send_key(9, 1'b0);
    send_rsp(1'b0); send_rsp(1'b0);
    exp_o(1, 1'b1, 1'b0);
    send_key(1, 1'b1);
    send_rsp(1'b1);
    drain();

    // Fill the in-flight FIFO; the 9th key stalls until one response pops.
    repeat (INFL_DEPTH) send_key(9, 1'b0);
    s_key_valid     = 1'b1;
    s_key_data.key  = agg_key_t'(9);
    s_key_data.last = 1'b0;
    @(negedge aclk);
    chk("full_key_ready", 32'(s_key_ready), 32'd0);
    chk("full_lup_valid", 32'(m_lup_req_valid), 32'd0);
    tick();
    exp_o(9, 1'b0, 1'b1); exp_u(9);
    send_rsp(1'b0);
    @(negedge aclk);
    chk("unfull_key_ready", 32'(s_key_ready), 32'd1);
    tick();
    s_key_valid = 1'b0;
    repeat (INFL_DEPTH) send_rsp(1'b0);
    exp_o(2, 1'b1, 1'b1); exp_u(2);
    send_key(2, 1'b1);
    send_rsp(1'b0);
    drain();

    // Output backpressure: responses stall, held output stays stable.
    m_out_ready = 1'b0;
    exp_o(4, 1'b0, 1'b1); exp_u(4);
    exp_o(6, 1'b0, 1'b1); exp_u(6);
    send_key(4, 1'b0); send_key(6, 1'b0);
    send_rsp(1'b0);
    s_lup_rsp_valid     = 1'b1;
    s_lup_rsp_data.key  = 16'hBEEF;
    s_lup_rsp_data.hit  = 1'b0;
    s_lup_rsp_data.last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("stall_rsp_ready", 32'(s_lup_rsp_ready), 32'd0);
      chk("stall_out_valid", 32'(m_out_valid), 32'd1);
      chk("stall_out_data", 32'(m_out_data), 32'(ob(4, 1'b0, 1'b1)));
    end
    tick();
    m_out_ready = 1'b1;
    send_rsp(1'b0);
    exp_o(8, 1'b1, 1'b1); exp_u(8);
    send_key(8, 1'b1);
    send_rsp(1'b0);
    drain();

    // Window cleared on last: 3 is new again in the next batch.
    exp_o(3, 1'b1, 1'b1); exp_u(3);
    send_key(3, 1'b1);
    send_rsp(1'b0);
    exp_o(3, 1'b1, 1'b1); exp_u(3);
    send_key(3, 1'b1);
    send_rsp(1'b0);
    drain();

    // Orphan response with an empty FIFO: not accepted, flag is sticky.
    s_lup_rsp_valid = 1'b1;
    @(negedge aclk);
    chk("orphan_rsp_ready", 32'(s_lup_rsp_ready), 32'd0);
    tick();
    s_lup_rsp_valid = 1'b0;
    @(negedge aclk);
    chk("orphan_err", 32'(err_orphan), 32'd1);
    repeat (3) tick();
    @(negedge aclk);
    chk("orphan_sticky", 32'(err_orphan), 32'd1);
    tick();

    // Reset mid-stream with pending outputs and an in-flight key.
    m_out_ready     = 1'b0;
    m_upd_req_ready = 1'b0;
    send_key(13, 1'b0);
    send_key(11, 1'b0);
    send_rsp(1'b0);
    @(negedge aclk);
    chk("pre_rst_out_valid", 32'(m_out_valid), 32'd1);
    tick();
    s_key_valid     = 1'b1;
    s_key_data.key  = agg_key_t'(12);
    s_key_data.last = 1'b0;
    aresetn         = 1'b0;
    @(negedge aclk);
    chk("mid_rst_lup_valid", 32'(m_lup_req_valid), 32'd0);
    chk("mid_rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("mid_rst_upd_valid", 32'(m_upd_req_valid), 32'd0);
    chk("mid_rst_err", 32'(err_orphan), 32'd0);
    tick();
    s_key_valid     = 1'b0;
    aresetn         = 1'b1;
    m_out_ready     = 1'b1;
    m_upd_req_ready = 1'b1;
    tick();
    s_lup_rsp_valid = 1'b1;
    @(negedge aclk);
    chk("post_rst_rsp_ready", 32'(s_lup_rsp_ready), 32'd0);
    tick();
    s_lup_rsp_valid = 1'b0;
    @(negedge aclk);
    chk("post_rst_orphan", 32'(err_orphan), 32'd1);
    tick();
    exp_o(20, 1'b1, 1'b1); exp_u(20);
    send_key(20, 1'b1);
    send_rsp(1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
